clock_timekeeper: RTL and testbench



---
 rtl/clock_timekeeper.sv | 168 ++++++++++++++++
 tb/tb_clock_timekeeper.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_timekeeper.sv
// Timekeeping core: 1 Hz prescaler, 12-hour h:m:s clock, alarm time/arming and gated buzzer tone.
// Optional alarm auto-stop after AUTOSTOP_SEC seconds of ringing: define CLOCK_TK_AUTOSTOP_EN.
module clock_timekeeper #(
  parameter int unsigned CLK_HZ   = 25_000_000,
  parameter int unsigned TONE_DIV = 7000,
  parameter int unsigned AL_STEP  = 10
`ifdef CLOCK_TK_AUTOSTOP_EN
  ,
  parameter int unsigned AUTOSTOP_SEC = 60
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_adj,
  input  logic       min_adj,
  input  logic       hrs_adj,
  input  logic       al_adj,
  input  logic       al_toggle,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [3:0] hours,
  output logic [5:0] al_minutes,
  output logic [3:0] al_hours,
  output logic       al_on,
  output logic       alarm,
  output logic       sec_tick,
  output logic       blink,
  output logic       buzzer_out
);

  localparam int unsigned PC_W   = $clog2(CLK_HZ);
  localparam int unsigned TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

  localparam logic [PC_W-1:0]   PC_LAST   = PC_W'(CLK_HZ - 1);
  localparam logic [PC_W-1:0]   PC_HALF   = PC_W'(CLK_HZ / 2);
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);
  localparam logic [6:0]        AL_STEP_W = 7'(AL_STEP);

  logic [PC_W-1:0]   pc, pc_nxt;
  logic [TONE_W-1:0] tone_cnt, tone_cnt_nxt;
  logic              tone, tone_nxt;
  logic              blink_nxt;
  logic              sec_tick_cond;

  logic              sec_inc, min_inc, hrs_inc;
  logic              sec_wrap, min_wrap;
  logic [5:0]        seconds_nxt, minutes_nxt, al_minutes_nxt;
  logic [3:0]        hours_nxt, al_hours_nxt;
  logic [6:0]        al_sum;

  logic              match, match_q, alarm_set;
  logic              al_on_nxt, alarm_nxt, buzzer_nxt;

`ifdef CLOCK_TK_AUTOSTOP_EN
  localparam logic [6:0] RING_LAST = 7'(AUTOSTOP_SEC);
  logic [6:0]        ring_cnt, ring_cnt_nxt;
`endif

  // Prescaler, blink decode (from next pc so the flop tracks pc) and free-running tone divider
  always_comb begin
    sec_tick_cond = (pc == PC_LAST);
    pc_nxt        = sec_tick_cond ? '0 : pc + PC_W'(1);
    blink_nxt     = (pc_nxt < PC_HALF);
    tone_cnt_nxt  = (tone_cnt == TONE_LAST) ? '0 : tone_cnt + TONE_W'(1);
    tone_nxt      = (tone_cnt == TONE_LAST) ? ~tone : tone;
  end

  // Time of day: same-cycle requests at each stage collapse to a single +1
  always_comb begin
    sec_inc     = sec_tick_cond | sec_adj;
    sec_wrap    = sec_inc & (seconds == 6'd59);
    seconds_nxt = seconds;
    if (sec_inc) seconds_nxt = sec_wrap ? 6'd0 : seconds + 6'd1;

    min_inc     = sec_wrap | min_adj;
    min_wrap    = min_inc & (minutes == 6'd59);
    minutes_nxt = minutes;
    if (min_inc) minutes_nxt = min_wrap ? 6'd0 : minutes + 6'd1;

    hrs_inc     = min_wrap | hrs_adj;
    hours_nxt   = hours;
    if (hrs_inc) hours_nxt = (hours == 4'd11) ? 4'd0 : hours + 4'd1;
  end

  // Alarm time steps by AL_STEP minutes, carrying into the hour
  always_comb begin
    al_sum         = 7'(al_minutes) + AL_STEP_W;
    al_minutes_nxt = al_minutes;
    al_hours_nxt   = al_hours;
    if (al_adj) begin
      if (al_sum >= 7'd60) begin
        al_minutes_nxt = 6'(al_sum - 7'd60);
        al_hours_nxt   = (al_hours == 4'd11) ? 4'd0 : al_hours + 4'd1;
      end else begin
        al_minutes_nxt = 6'(al_sum);
      end
    end
  end

  // Alarm rings on the rising edge of the time match; toggle outranks a same-cycle set
  always_comb begin
    match      = (hours == al_hours) & (minutes == al_minutes);
    alarm_set  = al_on & match & ~match_q;
    al_on_nxt  = al_on;
    alarm_nxt  = alarm;
    buzzer_nxt = alarm & blink & tone;
`ifdef CLOCK_TK_AUTOSTOP_EN
    ring_cnt_nxt = ring_cnt;
`endif
    if (al_toggle) begin
      if (al_on) begin
        al_on_nxt = 1'b0;
        alarm_nxt = 1'b0;
      end else begin
        al_on_nxt = 1'b1;
      end
    end else if (alarm_set) begin
      alarm_nxt = 1'b1;
`ifdef CLOCK_TK_AUTOSTOP_EN
      ring_cnt_nxt = 7'd0;
    end else if (alarm && sec_tick_cond) begin
      ring_cnt_nxt = ring_cnt + 7'd1;
      if (ring_cnt_nxt == RING_LAST) alarm_nxt = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= '0;
      tone_cnt   <= '0;
      tone       <= 1'b0;
      blink      <= 1'b1;
      sec_tick   <= 1'b0;
      seconds    <= 6'd0;
      minutes    <= 6'd0;
      hours      <= 4'd0;
      al_minutes <= 6'd0;
      al_hours   <= 4'd0;
      match_q    <= 1'b0;
      al_on      <= 1'b0;
      alarm      <= 1'b0;
      buzzer_out <= 1'b0;
`ifdef CLOCK_TK_AUTOSTOP_EN
      ring_cnt   <= 7'd0;
`endif
    end else begin
      pc         <= pc_nxt;
      tone_cnt   <= tone_cnt_nxt;
      tone       <= tone_nxt;
      blink      <= blink_nxt;
      sec_tick   <= sec_tick_cond;
      seconds    <= seconds_nxt;
      minutes    <= minutes_nxt;
      hours      <= hours_nxt;
      al_minutes <= al_minutes_nxt;
      al_hours   <= al_hours_nxt;
      match_q    <= match;
      al_on      <= al_on_nxt;
      alarm      <= alarm_nxt;
      buzzer_out <= buzzer_nxt;
`ifdef CLOCK_TK_AUTOSTOP_EN
      ring_cnt   <= ring_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_clock_timekeeper.sv
// Bench for clock_timekeeper: directed scenarios plus random adjust traffic against a
// time-of-day-in-seconds reference model; honours CLOCK_TK_AUTOSTOP_EN.
module tb_clock_timekeeper;

  localparam int CLK_HZ   = 10;
  localparam int TONE_DIV = 2;
  localparam int AL_STEP  = 10;
`ifdef CLOCK_TK_AUTOSTOP_EN
  localparam int AUTOSTOP_SEC = 3;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sec_adj = 1'b0, min_adj = 1'b0, hrs_adj = 1'b0, al_adj = 1'b0, al_toggle = 1'b0;
  logic [5:0] seconds, minutes, al_minutes;
  logic [3:0] hours, al_hours;
  logic       al_on, alarm, sec_tick, blink, buzzer_out;

  int total = 0;
  int bad   = 0;

  // Reference model: cycles since reset, time of day in seconds, alarm time in minutes
  int   m_c, m_tod, m_al, m_ring;
  logic m_on, m_alarm, m_mprev, m_buz;

  clock_timekeeper #(
    .CLK_HZ(CLK_HZ), .TONE_DIV(TONE_DIV), .AL_STEP(AL_STEP)
`ifdef CLOCK_TK_AUTOSTOP_EN
    , .AUTOSTOP_SEC(AUTOSTOP_SEC)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .sec_adj(sec_adj), .min_adj(min_adj), .hrs_adj(hrs_adj),
    .al_adj(al_adj), .al_toggle(al_toggle),
    .seconds(seconds), .minutes(minutes), .hours(hours),
    .al_minutes(al_minutes), .al_hours(al_hours),
    .al_on(al_on), .alarm(alarm), .sec_tick(sec_tick),
    .blink(blink), .buzzer_out(buzzer_out)
  );

  always #5 clk = ~clk;

  function automatic logic [30:0] obs();
    return {seconds, minutes, hours, al_minutes, al_hours, al_on, alarm, sec_tick, blink, buzzer_out};
  endfunction

  function automatic logic [30:0] expv();
    logic tick_e, blink_e;
    tick_e  = (m_c > 0) && ((m_c % CLK_HZ) == 0);
    blink_e = (m_c % CLK_HZ) < (CLK_HZ / 2);
    return {6'(m_tod % 60), 6'((m_tod / 60) % 60), 4'(m_tod / 3600),
            6'(m_al % 60), 4'(m_al / 60), m_on, m_alarm, tick_e, blink_e, m_buz};
  endfunction

  task automatic model_reset();
    m_c = 0; m_tod = 0; m_al = 0; m_ring = 0;
    m_on = 1'b0; m_alarm = 1'b0; m_mprev = 1'b0; m_buz = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // One clock with the given pulses; afterwards advance the model and leave time at edge+1
  task automatic step(input logic sa, input logic ma, input logic ha, input logic aa, input logic at);
    int   s, m, nt;
    logic tick, sinc, scarry, mcarry, match, set_e, blink0, tone0;
    sec_adj = sa; min_adj = ma; hrs_adj = ha; al_adj = aa; al_toggle = at;
    @(posedge clk);
    #1;
    sec_adj = 1'b0; min_adj = 1'b0; hrs_adj = 1'b0; al_adj = 1'b0; al_toggle = 1'b0;
    s      = m_tod % 60;
    m      = (m_tod / 60) % 60;
    tick   = (m_c % CLK_HZ) == (CLK_HZ - 1);
    blink0 = (m_c % CLK_HZ) < (CLK_HZ / 2);
    tone0  = ((m_c / TONE_DIV) % 2) == 1;
    sinc   = tick | sa;
    scarry = sinc && (s == 59);
    mcarry = (scarry || ma) && (m == 59);
    match  = (m_tod / 60) == m_al;
    set_e  = m_on && match && !m_mprev;
    nt = m_tod + (sinc ? 1 : 0);
    if (ma && !scarry) nt += 60;
    if (ha && !mcarry) nt += 3600;
    m_tod = nt % 43200;
    if (aa) m_al = (m_al + AL_STEP) % 720;
    m_buz = m_alarm && blink0 && tone0;
    if (at) begin
      if (m_on) begin m_on = 1'b0; m_alarm = 1'b0; end
      else m_on = 1'b1;
    end else if (set_e) begin
      m_alarm = 1'b1;
      m_ring  = 0;
    end
`ifdef CLOCK_TK_AUTOSTOP_EN
    else if (m_alarm && tick) begin
      m_ring++;
      if (m_ring == AUTOSTOP_SEC) m_alarm = 1'b0;
    end
`endif
    m_mprev = match;
    m_c++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Bring seconds to 59 with sec_adj, never pulsing on a tick edge
  task automatic set_sec59();
    int guard;
    guard = 0;
    while ((m_tod % 60) != 59 && guard < 200) begin
      if ((m_c % CLK_HZ) == (CLK_HZ - 1)) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      else step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    if ((m_tod % 60) != 59) begin
      total++; bad++;
      $display("FAIL set_sec59 timeout: model seconds=%0d required=59", m_tod % 60);
    end
  endtask

  // Alarm 0:10 armed, time 0:09:59, stop on the edge where minutes become 10
  task automatic setup_ringing();
    int guard;
    apply_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_sec59();
    guard = 0;
    while (((m_tod / 60) % 60) != 10 && guard < 2 * CLK_HZ) begin
      idle(1);
      guard++;
    end
    if (((m_tod / 60) % 60) != 10) begin
      total++; bad++;
      $display("FAIL setup_ringing timeout: model minutes=%0d required=10", (m_tod / 60) % 60);
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    total++;
    if (obs() !== 31'h2) begin bad++; $display("FAIL reset_held: got=%h exp=%h", obs(), 31'h2); end
    reset = 1'b0;
    model_reset();
    total++;
    if (obs() !== expv()) begin bad++; $display("FAIL reset_release: got=%h exp=%h", obs(), expv()); end
    for (int i = 0; i < 37; i++)
      step(1'($urandom_range(3, 0) == 0), 1'($urandom_range(3, 0) == 0), 1'($urandom_range(3, 0) == 0),
           1'($urandom_range(3, 0) == 0), 1'($urandom_range(7, 0) == 0));
    total++;
    if (obs() !== expv()) begin bad++; $display("FAIL pre_reset_state: got=%h exp=%h", obs(), expv()); end
    reset = 1'b1;
    #1;
    total++;
    if (obs() !== 31'h2) begin bad++; $display("FAIL reset_async_clear: got=%h exp=%h", obs(), 31'h2); end
    #1;
    reset = 1'b0;
    model_reset();
    idle(1);
    total++;
    if (obs() !== expv()) begin bad++; $display("FAIL reset_restart: got=%h exp=%h", obs(), expv()); end
  endtask

  task automatic test_prescaler();
    apply_reset();
    for (int i = 1; i <= 600; i++) begin
      idle(1);
      total++;
      if (sec_tick !== ((i % 10) == 0)) begin bad++; $display("FAIL sec_tick cyc=%0d: got=%b exp=%b", i, sec_tick, (i % 10) == 0); end
      total++;
      if (blink !== ((i % 10) < 5)) begin bad++; $display("FAIL blink cyc=%0d: got=%b exp=%b", i, blink, (i % 10) < 5); end
      if (i == 590) begin
        total++;
        if ({minutes, seconds} !== {6'd0, 6'd59}) begin bad++; $display("FAIL at_590 m:s: got=%0d:%0d exp=0:59", minutes, seconds); end
      end
      if (i == 600) begin
        total++;
        if ({minutes, seconds} !== {6'd1, 6'd0}) begin bad++; $display("FAIL at_600 m:s: got=%0d:%0d exp=1:0", minutes, seconds); end
      end
    end
    total++;
    if (obs() !== expv()) begin bad++; $display("FAIL prescaler_model: got=%h exp=%h", obs(), expv()); end
  endtask

  task automatic test_rollover();
    int guard;
    apply_reset();
    for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 59; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_sec59();
    total++;
    if ({hours, minutes, seconds} !== {4'd11, 6'd59, 6'd59}) begin
      bad++; $display("FAIL set_115959: got=%0d:%0d:%0d exp=11:59:59", hours, minutes, seconds);
    end
    guard = 0;
    do begin idle(1); guard++; end while (sec_tick !== 1'b1 && guard < 2 * CLK_HZ);
    total++;
    if ({hours, minutes, seconds} !== 16'd0 || sec_tick !== 1'b1) begin
      bad++; $display("FAIL rollover_000000: got=%0d:%0d:%0d tick=%b exp=0:0:0 tick=1", hours, minutes, seconds, sec_tick);
    end
    idle(CLK_HZ);
    total++;
    if ({hours, minutes, seconds} !== {4'd0, 6'd0, 6'd1}) begin
      bad++; $display("FAIL after_rollover: got=%0d:%0d:%0d exp=0:0:1", hours, minutes, seconds);
    end
  endtask

  task automatic test_collapse();
    int s0, m0, guard;
    guard = 0;
    while ((m_c % CLK_HZ) != (CLK_HZ - 1) && guard < 2 * CLK_HZ) begin idle(1); guard++; end
    s0 = m_tod % 60;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (seconds !== 6'((s0 + 1) % 60)) begin bad++; $display("FAIL sec_collapse: got=%0d exp=%0d", seconds, (s0 + 1) % 60); end
    set_sec59();
    guard = 0;
    while ((m_c % CLK_HZ) != (CLK_HZ - 1) && guard < 2 * CLK_HZ) begin idle(1); guard++; end
    m0 = (m_tod / 60) % 60;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if ({minutes, seconds} !== {6'((m0 + 1) % 60), 6'd0}) begin
      bad++; $display("FAIL min_collapse: got=%0d:%0d exp=%0d:0", minutes, seconds, (m0 + 1) % 60);
    end
  endtask

  task automatic test_al_adj();
    int exp_m [6] = '{10, 20, 30, 40, 50, 0};
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      total++;
      if (al_minutes !== 6'(exp_m[k]) || al_hours !== ((k == 5) ? 4'd1 : 4'd0)) begin
        bad++; $display("FAIL al_adj_%0d: got=%0d:%0d exp=%0d:%0d", k + 1, al_hours, al_minutes, (k == 5) ? 1 : 0, exp_m[k]);
      end
    end
  endtask

  task automatic test_arm_matching();
    apply_reset();
    idle(3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (al_on !== 1'b1) begin bad++; $display("FAIL arm_on: got=%b exp=1", al_on); end
    for (int i = 0; i < 20; i++) begin
      idle(1);
      total++;
      if (alarm !== 1'b0) begin bad++; $display("FAIL arm_in_match cyc=%0d: alarm got=%b exp=0", i, alarm); end
    end
  endtask

  task automatic test_alarm();
    int   highs;
    logic prev_blink;
    setup_ringing();
    total++;
    if (minutes !== 6'd10 || alarm !== 1'b0) begin bad++; $display("FAIL alarm_pre: min=%0d alarm=%b exp 10/0", minutes, alarm); end
    idle(1);
    total++;
    if (alarm !== 1'b1) begin bad++; $display("FAIL alarm_rise: got=%b exp=1", alarm); end
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      prev_blink = (m_c % CLK_HZ) < (CLK_HZ / 2);
      idle(1);
      total++;
      if (buzzer_out !== m_buz) begin bad++; $display("FAIL buzzer cyc=%0d: got=%b exp=%b", i, buzzer_out, m_buz); end
      if (!prev_blink) begin
        total++;
        if (buzzer_out !== 1'b0) begin bad++; $display("FAIL buzzer_blink_low cyc=%0d: got=%b exp=0", i, buzzer_out); end
      end
      if (buzzer_out === 1'b1) highs++;
    end
    total++;
    if (highs == 0) begin bad++; $display("FAIL buzzer_active: highs got=%0d exp>0", highs); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (al_on !== 1'b0 || alarm !== 1'b0) begin bad++; $display("FAIL toggle_off: al_on=%b alarm=%b exp 0/0", al_on, alarm); end
    idle(1);
    total++;
    if (buzzer_out !== 1'b0) begin bad++; $display("FAIL buzzer_off: got=%b exp=0", buzzer_out); end
  endtask

  task automatic test_autostop();
    int ticks, guard;
    setup_ringing();
    idle(1);
    total++;
    if (alarm !== 1'b1) begin bad++; $display("FAIL ring_start: got=%b exp=1", alarm); end
    ticks = 0;
    guard = 0;
`ifdef CLOCK_TK_AUTOSTOP_EN
    while (ticks < 3 && guard < 10 * CLK_HZ) begin
      idle(1);
      guard++;
      if (sec_tick === 1'b1) ticks++;
      total++;
      if (alarm !== ((ticks < 3) ? 1'b1 : 1'b0)) begin
        bad++; $display("FAIL autostop tick=%0d: alarm got=%b exp=%b", ticks, alarm, ticks < 3);
      end
    end
    total++;
    if (ticks != 3 || al_on !== 1'b1) begin bad++; $display("FAIL autostop_end: ticks=%0d al_on=%b exp 3/1", ticks, al_on); end
`else
    while (ticks < 100 && guard < 110 * CLK_HZ) begin
      idle(1);
      guard++;
      if (sec_tick === 1'b1) ticks++;
    end
    total++;
    if (ticks != 100 || alarm !== 1'b1 || al_on !== 1'b1) begin
      bad++; $display("FAIL alarm_hold: ticks=%0d alarm=%b al_on=%b exp 100/1/1", ticks, alarm, al_on);
    end
`endif
    total++;
    if (obs() !== expv()) begin bad++; $display("FAIL autostop_model: got=%h exp=%h", obs(), expv()); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(7, 0) == 0), 1'($urandom_range(5, 0) == 0), 1'($urandom_range(15, 0) == 0),
           1'($urandom_range(9, 0) == 0), 1'($urandom_range(29, 0) == 0));
      total++;
      if (obs() !== expv()) begin bad++; $display("FAIL random cyc=%0d: got=%h exp=%h", i, obs(), expv()); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_prescaler();
    test_rollover();
    test_collapse();
    test_al_adj();
    test_arm_matching();
    test_alarm();
    test_autostop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
